// File: rtl/button_conditioner.sv
// Button/switch input conditioner for the pong core: two-flop synchronizer,
// shared prescaler tick and per-channel tick-based debounce with registered
// press/release pulses. All outputs are registered in the pixel clock domain.
module button_conditioner #(
    parameter int WIDTH          = 7,
    parameter int PRESCALE       = 25125,
    parameter int DEBOUNCE_TICKS = 10,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    // Pin value of an unpressed button; also the polarity flip mask.
    localparam logic [WIDTH-1:0] IDLE     = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0]         sync1_q, sync2_q, pressed_sync;
    logic [PW-1:0]            pre_q, pre_d;
    logic                     tick_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         press_q, press_d;
    logic [WIDTH-1:0]         rel_q, rel_d;

    // Two-flop synchronizer; reset loads the idle pin value so no false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_sync = sync2_q ^ IDLE;

    // Prescaler next count: 0..PRESCALE-1 then wrap.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    // Prescaler register; tick is compared against the next count so it is
    // high in the same cycle the count sits at PRESCALE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PRE_LAST);
        end
    end

    // Debounce next state: any agreeing cycle restarts the count, a new level
    // is accepted on the DEBOUNCE_TICKS-th consecutive disagreeing tick.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pressed_sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = pressed_sync[i];
                    press_d[i] = pressed_sync[i];
                    rel_d[i]   = ~pressed_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = rel_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: main instance at PRESCALE=4,
// DEBOUNCE_TICKS=3, plus a PRESCALE=1, DEBOUNCE_TICKS=1 instance.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn_raw, btn_level, btn_press, btn_release;
    logic       tick;
    logic [6:0] raw2, level2, press2, rel2;
    logic       tick2;

    int errors = 0;
    int checks = 0;

    // Results of the last measure call.
    int np, nr, n;
    logic pulse_at, oth;

    always #5 clk = ~clk;

    button_conditioner #(.WIDTH(7), .PRESCALE(4), .DEBOUNCE_TICKS(3), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .tick(tick)
    );

    button_conditioner #(.WIDTH(7), .PRESCALE(1), .DEBOUNCE_TICKS(1), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw2), .btn_level(level2),
        .btn_press(press2), .btn_release(rel2), .tick(tick2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count edges until btn_level[ch]==want (n=0 if never), over a 20-edge
    // window; also tally pulses on ch and changes on other channels.
    task automatic measure(input int ch, input logic want);
        logic [6:0] snap;
        logic [6:0] mask;
        snap = btn_level;
        mask = 7'(1 << ch);
        n = 0; np = 0; nr = 0; pulse_at = 1'b0; oth = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            np += int'(btn_press[ch]);
            nr += int'(btn_release[ch]);
            if (((btn_level ^ snap) & ~mask) != 7'd0) oth = 1'b1;
            if (n == 0 && btn_level[ch] == want) begin
                n = k;
                pulse_at = want ? btn_press[ch] : btn_release[ch];
            end
        end
    endtask

    initial begin
        logic [6:0] acc;
        int ntick;

        // Reset state with idle pins
        rst_n = 1'b0; btn_raw = 7'h7F; raw2 = 7'h7F;
        repeat (3) step();
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_release", btn_release, 0);
        chk("rst_tick", tick, 0);
        rst_n = 1'b1;
        acc = '0; ntick = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            acc |= btn_level | btn_press | btn_release;
            ntick += int'(tick);
        end
        chk("idle_quiet", acc, 0);
        chk("idle_tick_count", ntick, 25);
        chk("p1_tick_every_cycle", tick2, 1);

        // Clean press on ch0
        btn_raw[0] = 1'b0;
        measure(0, 1'b1);
        chk("press_lat_11_14", (n >= 11 && n <= 14), 1);
        chk("press_pulse_aligned", pulse_at, 1);
        chk("press_pulse_count", np, 1);
        chk("press_no_release", nr, 0);
        chk("press_others_stable", oth, 0);

        // Bounce on ch2, then settle low
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            btn_raw[2] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            acc[0] = acc[0] | btn_level[2] | btn_press[2];
        end
        chk("bounce_no_level", acc[0], 0);
        btn_raw[2] = 1'b0;
        measure(2, 1'b1);
        chk("bounce_lat_11_14", (n >= 11 && n <= 14), 1);
        chk("bounce_pulse_count", np, 1);
        chk("bounce_pulse_aligned", pulse_at, 1);

        // Release ch0
        btn_raw[0] = 1'b1;
        measure(0, 1'b0);
        chk("rel_lat_11_14", (n >= 11 && n <= 14), 1);
        chk("rel_pulse_aligned", pulse_at, 1);
        chk("rel_pulse_count", nr, 1);
        chk("rel_no_press", np, 0);

        // Simultaneous press on ch1 and ch6
        btn_raw[1] = 1'b0; btn_raw[6] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (btn_press != 7'd0) break;
        end
        chk("simul_press", btn_press, 7'b100_0010);
        step();
        chk("simul_press_one_cycle", btn_press, 0);

        // Release everything, then reset in the middle of a ch3 count
        btn_raw = 7'h7F;
        repeat (30) step();
        chk("all_released", btn_level, 0);
        btn_raw[3] = 1'b0;
        repeat (8) step();
        chk("midcount_not_yet", btn_level[3], 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        measure(3, 1'b1);
        chk("midcount_lat_11_14", (n >= 11 && n <= 14), 1);
        chk("midcount_pulse_count", np, 1);

        // PRESCALE=1, DEBOUNCE_TICKS=1: level follows pin 3 cycles later
        raw2[0] = 1'b0;
        step(); step();
        chk("p1_level_early", level2[0], 0);
        step();
        chk("p1_level_3cyc", level2[0], 1);
        chk("p1_press", press2[0], 1);
        step();
        chk("p1_press_one_cycle", press2[0], 0);

        // Asynchronous reset assertion between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", btn_level, 0);
        chk("async_rst_level2", level2, 0);
        chk("async_rst_tick2", tick2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
